// File: rtl/memory_unit_pkg.sv
// Shared defaults and helpers for the RISC-SPM word-addressed RAM.
package memory_unit_pkg;

  localparam int WORD_SIZE_DEF = 8;
  localparam int MEM_SIZE_DEF  = 256;

  // Bits needed to index mem_size words; never less than one.
  function automatic int addr_width(input int mem_size);
    return (mem_size > 1) ? $clog2(mem_size) : 1;
  endfunction

endpackage : memory_unit_pkg

// File: rtl/memory_unit_if.sv
// Address/data bus between the processor registers and the RAM.
interface memory_unit_if
  import memory_unit_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
);

  logic [WORD_SIZE-1:0] data_in;
  logic [WORD_SIZE-1:0] address;
  logic                 write;
  logic [WORD_SIZE-1:0] data_out;

  modport master (output data_in, output address, output write, input data_out);
  modport slave  (input data_in, input address, input write, output data_out);

endinterface : memory_unit_if

// File: rtl/memory_unit_core.sv
// Storage array with a synchronous write port and an asynchronous, range-checked
// read port. Reusable for the ROM variant by tying write low.
module memory_unit_core
  import memory_unit_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MEM_SIZE  = MEM_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out
);

  localparam int                 AW    = addr_width(MEM_SIZE);
  localparam logic [WORD_SIZE:0] LIMIT = (WORD_SIZE + 1)'(MEM_SIZE);

  logic [WORD_SIZE-1:0] mem [0:MEM_SIZE-1];
  logic [AW-1:0]        index;
  logic                 in_range;

  // Addresses past the end of the array are never wrapped onto real words.
  assign index    = address[AW-1:0];
  assign in_range = ({1'b0, address} < LIMIT);

  // Clear every word on reset; otherwise store data_in on a legal write.
  // NOTE: resetting the whole array forces flops instead of a RAM macro; the
  // machine relies on memory reading zero immediately after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        // NOTE: non-blocking so every reader in this time step sees pre-edge contents.
        mem[i] <= '0;
      end
    end else if (write && in_range) begin
      mem[index] <= data_in;
    end
  end

  // Zero-latency read; out-of-range addresses read as zero.
  assign data_out = in_range ? mem[index] : '0;

endmodule : memory_unit_core

// File: rtl/memory_unit.sv
// Single-port RAM holding program and data words for the RISC-SPM datapath.
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MEM_SIZE  = MEM_SIZE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  memory_unit_if.slave  bus
);

  memory_unit_core #(
    .WORD_SIZE (WORD_SIZE),
    .MEM_SIZE  (MEM_SIZE)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .write    (bus.write),
    .address  (bus.address),
    .data_in  (bus.data_in),
    .data_out (bus.data_out)
  );

endmodule : memory_unit

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: a full 256-word instance plus a 16-word
// instance for out-of-range addresses.
module tb_memory_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  memory_unit_if #(.WORD_SIZE(8)) bus ();
  memory_unit_if #(.WORD_SIZE(8)) bus_s ();

  memory_unit #(.WORD_SIZE(8), .MEM_SIZE(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  memory_unit #(.WORD_SIZE(8), .MEM_SIZE(16)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write one word on the next rising edge; inputs change on the falling edge.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address = a;
    bus.data_in = d;
    bus.write   = 1'b1;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] addrs [3];
    addrs = '{8'h00, 8'h0A, 8'hFF};
    bus.address = 8'h00; bus.data_in = 8'h00; bus.write = 1'b0;
    bus_s.address = 8'h00; bus_s.data_in = 8'h00; bus_s.write = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    foreach (addrs[i]) begin
      bus.address = addrs[i];
      #1;
      n_checks++;
      if (bus.data_out !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_clear addr=%h got=%h exp=00", addrs[i], bus.data_out);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    bus.address = 8'h00;
    #1;
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=00", bus.data_out);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.address = 8'h0A;
    bus.data_in = 8'h55;
    bus.write   = 1'b1;
    #1;
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL write_before_edge got=%h exp=00", bus.data_out);
    end
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    n_checks++;
    if (bus.data_out !== 8'h55) begin
      n_fail++;
      $display("FAIL write_after_edge got=%h exp=55", bus.data_out);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.data_out !== 8'h55) begin
      n_fail++;
      $display("FAIL write_retained got=%h exp=55", bus.data_out);
    end
  endtask

  task automatic test_overwrite();
    do_write(8'h0A, 8'hAA);
    n_checks++;
    if (bus.data_out !== 8'hAA) begin
      n_fail++;
      $display("FAIL overwrite_toggle got=%h exp=aa", bus.data_out);
    end
    bus.address = 8'h0B;
    #1;
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL neighbour_untouched got=%h exp=00", bus.data_out);
    end
  endtask

  task automatic test_no_write();
    @(negedge clk);
    bus.address = 8'h0A;
    bus.write   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = (i == 0) ? 8'hFF : 8'h0F;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.data_out !== 8'hAA) begin
        n_fail++;
        $display("FAIL write_low_hold cycle=%0d got=%h exp=aa", i, bus.data_out);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_boundary();
    do_write(8'h00, 8'h01);
    do_write(8'hFF, 8'h80);
    bus.address = 8'h00;
    #1;
    n_checks++;
    if (bus.data_out !== 8'h01) begin
      n_fail++;
      $display("FAIL boundary_low got=%h exp=01", bus.data_out);
    end
    bus.address = 8'hFF;
    #1;
    n_checks++;
    if (bus.data_out !== 8'h80) begin
      n_fail++;
      $display("FAIL boundary_high got=%h exp=80", bus.data_out);
    end
    bus.address = 8'h7F;
    #1;
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL boundary_alias got=%h exp=00", bus.data_out);
    end
  endtask

  // write held high: each edge stores the current address/data pair.
  task automatic test_back_to_back();
    logic [7:0] a_vec [3];
    logic [7:0] d_vec [3];
    a_vec = '{8'h20, 8'h20, 8'h21};
    d_vec = '{8'h11, 8'h22, 8'h33};
    @(negedge clk);
    bus.write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.address = a_vec[i];
      bus.data_in = d_vec[i];
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.data_out !== d_vec[i]) begin
        n_fail++;
        $display("FAIL held_write step=%0d got=%h exp=%h", i, bus.data_out, d_vec[i]);
      end
      @(negedge clk);
    end
    bus.write   = 1'b0;
    bus.address = 8'h20;
    #1;
    n_checks++;
    if (bus.data_out !== 8'h22) begin
      n_fail++;
      $display("FAIL held_write_last_wins got=%h exp=22", bus.data_out);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] a_vec [3];
    logic [7:0] e_vec [3];
    a_vec = '{8'h0F, 8'h10, 8'h00};
    e_vec = '{8'hC3, 8'h00, 8'h00};
    @(negedge clk);
    bus_s.address = 8'h0F; bus_s.data_in = 8'hC3; bus_s.write = 1'b1;
    @(negedge clk);
    bus_s.address = 8'h10; bus_s.data_in = 8'h77;
    @(negedge clk);
    bus_s.write = 1'b0;
    foreach (a_vec[i]) begin
      bus_s.address = a_vec[i];
      #1;
      n_checks++;
      if (bus_s.data_out !== e_vec[i]) begin
        n_fail++;
        $display("FAIL out_of_range addr=%h got=%h exp=%h", a_vec[i], bus_s.data_out, e_vec[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.address = 8'h0A;
    #1;
    n_checks++;
    if (bus.data_out !== 8'hAA) begin
      n_fail++;
      $display("FAIL pre_reset_value got=%h exp=aa", bus.data_out);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_immediate got=%h exp=00", bus.data_out);
    end
    bus.data_in = 8'h5A;
    bus.write   = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL write_during_reset got=%h exp=00", bus.data_out);
    end
    bus.write   = 1'b0;
    bus.address = 8'hFF;
    #1;
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_clears_high got=%h exp=00", bus.data_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write();
    test_overwrite();
    test_no_write();
    test_boundary();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_memory_unit
